// File: rtl/uart_rx_sipo_pkg.sv
// Shared definitions for the UART receive path: parity codes, FSM states and the default
// oversampling ratio.
package uart_rx_sipo_pkg;

    parameter int unsigned OverSampleDef = 16;

    localparam logic [1:0] ParOdd  = 2'b01;
    localparam logic [1:0] ParEven = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } rx_state_e;

    function automatic logic parity_en(input logic [1:0] par);
        return (par == ParOdd) || (par == ParEven);
    endfunction

endpackage

// File: rtl/uart_rx_sipo_sampler.sv
// Input conditioning for the serial line: 2-flop synchroniser, falling-edge detect and a
// 3-tap majority vote over the last three synchronised samples.
module uart_rx_sipo_sampler (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic sync_bit_o,
    output logic fall_edge_o,
    output logic maj_bit_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       prev2_q;

    // Everything resets high so an idle line never looks like a start edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            prev2_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= sync_q[1];
            prev2_q <= prev_q;
        end
    end

    assign sync_bit_o  = sync_q[1];
    assign fall_edge_o = prev_q & ~sync_q[1];
    assign maj_bit_o   = (sync_q[1] & prev_q) | (sync_q[1] & prev2_q) | (prev_q & prev2_q);

endmodule

// File: rtl/uart_rx_sipo.sv
// UART serial-in/parallel-out receiver: start detection, data/parity/stop sampling and
// framing/parity error reporting, clocked by the oversampled baud tick.
module uart_rx_sipo
    import uart_rx_sipo_pkg::*;
#(
    parameter int unsigned OverSample = OverSampleDef,
    parameter int unsigned DataMax    = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rx_i,
    input  logic [1:0]         parity_type_i,
    input  logic               stop_bits_i,
    input  logic               data_length_i,
    output logic [DataMax-1:0] data_parll_o,
    output logic               done_flag_o,
    output logic               active_flag_o,
    output logic               parity_error_o,
    output logic               stop_error_o
);

    localparam int unsigned TickW = $clog2(OverSample);
    localparam int unsigned BitW  = $clog2(DataMax);
    // Majority decision is taken once the third tap (OverSample/2+1) is in.
    localparam logic [TickW-1:0] MidTick  = TickW'(OverSample / 2 + 1);
    localparam logic [TickW-1:0] LastTick = TickW'(OverSample - 1);
    localparam logic [BitW-1:0]  LastBit8 = BitW'(DataMax - 1);
    localparam logic [BitW-1:0]  LastBit7 = BitW'(DataMax - 2);

    logic sync_bit, fall_edge, maj_bit;

    uart_rx_sipo_sampler u_sampler (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (rx_i),
        .sync_bit_o  (sync_bit),
        .fall_edge_o (fall_edge),
        .maj_bit_o   (maj_bit)
    );

    rx_state_e          state_q, state_d;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [BitW-1:0]    bit_q, bit_d;
    logic [DataMax-1:0] shift_q, shift_d;
    logic [DataMax-1:0] data_q, data_d;
    logic [1:0]         par_q, par_d;
    logic               stop2_q, stop2_d;
    logic               len8_q, len8_d;
    logic               stop_cnt_q, stop_cnt_d;
    logic               active_q, active_d;
    logic               perr_q, perr_d;
    logic               serr_q, serr_d;
    logic               pend_perr_q, pend_perr_d;
    logic               pend_serr_q, pend_serr_d;
    logic               is_mid, stop_err_now;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            par_q       <= '0;
            stop2_q     <= 1'b0;
            len8_q      <= 1'b0;
            stop_cnt_q  <= 1'b0;
            active_q    <= 1'b0;
            perr_q      <= 1'b0;
            serr_q      <= 1'b0;
            pend_perr_q <= 1'b0;
            pend_serr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            par_q       <= par_d;
            stop2_q     <= stop2_d;
            len8_q      <= len8_d;
            stop_cnt_q  <= stop_cnt_d;
            active_q    <= active_d;
            perr_q      <= perr_d;
            serr_q      <= serr_d;
            pend_perr_q <= pend_perr_d;
            pend_serr_q <= pend_serr_d;
        end
    end

    assign is_mid       = (tick_q == MidTick);
    assign stop_err_now = pend_serr_q | ~maj_bit;

    always_comb begin
        state_d     = state_q;
        tick_d      = (tick_q == LastTick) ? '0 : tick_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        par_d       = par_q;
        stop2_d     = stop2_q;
        len8_d      = len8_q;
        stop_cnt_d  = stop_cnt_q;
        active_d    = active_q;
        perr_d      = perr_q;
        serr_d      = serr_q;
        pend_perr_d = pend_perr_q;
        pend_serr_d = pend_serr_q;

        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                if (fall_edge && !sync_bit) begin
                    state_d = StStart;
                    tick_d  = TickW'(1);
                    par_d   = parity_type_i;
                    stop2_d = stop_bits_i;
                    len8_d  = data_length_i;
                end
            end
            StStart: begin
                if (is_mid) begin
                    if (maj_bit) begin
                        state_d = StIdle;
                        tick_d  = '0;
                    end else begin
                        state_d     = StData;
                        active_d    = 1'b1;
                        perr_d      = 1'b0;
                        serr_d      = 1'b0;
                        pend_perr_d = 1'b0;
                        pend_serr_d = 1'b0;
                        shift_d     = '0;
                        bit_d       = '0;
                    end
                end
            end
            StData: begin
                if (is_mid) begin
                    shift_d = {maj_bit, shift_q[DataMax-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == (len8_q ? LastBit8 : LastBit7)) begin
                        state_d    = parity_en(par_q) ? StParity : StStop;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            StParity: begin
                if (is_mid) begin
                    // Unused shift bits are zero, so the full-width XOR covers 7-bit frames too.
                    pend_perr_d = (^shift_q) ^ maj_bit ^ (par_q == ParOdd);
                    state_d     = StStop;
                    stop_cnt_d  = 1'b0;
                end
            end
            StStop: begin
                if (is_mid) begin
                    if (stop_cnt_q == stop2_q) begin
                        state_d  = StDone;
                        data_d   = len8_q ? shift_q : {1'b0, shift_q[DataMax-1:1]};
                        serr_d   = stop_err_now;
                        perr_d   = pend_perr_q;
                        active_d = 1'b0;
                    end else begin
                        stop_cnt_d  = 1'b1;
                        pend_serr_d = stop_err_now;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                tick_d  = '0;
            end
            default: begin
                state_d = StIdle;
                tick_d  = '0;
            end
        endcase
    end

    assign data_parll_o   = data_q;
    assign done_flag_o    = (state_q == StDone);
    assign active_flag_o  = active_q;
    assign parity_error_o = perr_q;
    assign stop_error_o   = serr_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: drives complete serial frames at 16 ticks per bit and checks
// received data, pulse counts and error flags against hand-computed values.
module tb_uart_rx_sipo;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [1:0] par_type;
    logic       stop_bits;
    logic       data_len;
    logic [7:0] data_parll;
    logic       done_flag;
    logic       active_flag;
    logic       parity_error;
    logic       stop_error;

    int n_tests = 0;
    int n_fail  = 0;

    int         done_cnt   = 0;
    int         active_cnt = 0;
    logic [7:0] got_q[$];

    uart_rx_sipo dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .rx_i           (rx),
        .parity_type_i  (par_type),
        .stop_bits_i    (stop_bits),
        .data_length_i  (data_len),
        .data_parll_o   (data_parll),
        .done_flag_o    (done_flag),
        .active_flag_o  (active_flag),
        .parity_error_o (parity_error),
        .stop_error_o   (stop_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_flag === 1'b1) begin
            done_cnt = done_cnt + 1;
            got_q.push_back(data_parll);
        end
        if (active_flag === 1'b1) active_cnt = active_cnt + 1;
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic [1:0] par,
                              input bit flip, input int nstop, input bit stop_low,
                              input int idle);
        logic p;
        par_type  = par;
        stop_bits = (nstop == 2);
        data_len  = (nbits == 8);
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ d[i];
        if (par == 2'b01) p = ~p;
        if (flip) p = ~p;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (par == 2'b01 || par == 2'b10) send_bit(p);
        for (int i = 0; i < nstop; i++) send_bit(stop_low ? 1'b0 : 1'b1);
        rx = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1; par_type = 2'b00; stop_bits = 1'b0; data_len = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (data_parll !== 8'h00) begin n_fail++;
            $display("FAIL reset_data got=%h exp=00", data_parll); end
        n_tests++; if (done_flag !== 1'b0) begin n_fail++;
            $display("FAIL reset_done got=%b exp=0", done_flag); end
        n_tests++; if (active_flag !== 1'b0) begin n_fail++;
            $display("FAIL reset_active got=%b exp=0", active_flag); end
        n_tests++; if (parity_error !== 1'b0) begin n_fail++;
            $display("FAIL reset_perr got=%b exp=0", parity_error); end
        n_tests++; if (stop_error !== 1'b0) begin n_fail++;
            $display("FAIL reset_serr got=%b exp=0", stop_error); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_8n1();
        int d0, a0;
        d0 = done_cnt; a0 = active_cnt;
        send_frame(8'hA5, 8, 2'b00, 1'b0, 1, 1'b0, 20);
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++;
            $display("FAIL 8n1_pulses got=%0d exp=1", done_cnt - d0); end
        n_tests++; if (data_parll !== 8'hA5) begin n_fail++;
            $display("FAIL 8n1_data got=%h exp=a5", data_parll); end
        n_tests++; if (active_cnt == a0) begin n_fail++;
            $display("FAIL 8n1_active_seen got=0 exp=nonzero"); end
        n_tests++; if (active_flag !== 1'b0) begin n_fail++;
            $display("FAIL 8n1_active_after got=%b exp=0", active_flag); end
        n_tests++; if ({parity_error, stop_error} !== 2'b00) begin n_fail++;
            $display("FAIL 8n1_errors got=%b exp=00", {parity_error, stop_error}); end
    endtask

    task automatic test_7e2();
        int d0;
        d0 = done_cnt;
        send_frame(8'h55, 7, 2'b10, 1'b0, 2, 1'b0, 20);
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++;
            $display("FAIL 7e2_pulses got=%0d exp=1", done_cnt - d0); end
        n_tests++; if (data_parll !== 8'h55) begin n_fail++;
            $display("FAIL 7e2_data got=%h exp=55", data_parll); end
        n_tests++; if (parity_error !== 1'b0) begin n_fail++;
            $display("FAIL 7e2_perr got=%b exp=0", parity_error); end
        send_frame(8'h55, 7, 2'b10, 1'b1, 2, 1'b0, 20);
        n_tests++; if (data_parll !== 8'h55) begin n_fail++;
            $display("FAIL 7e2_flip_data got=%h exp=55", data_parll); end
        n_tests++; if (parity_error !== 1'b1) begin n_fail++;
            $display("FAIL 7e2_flip_perr got=%b exp=1", parity_error); end
        n_tests++; if (stop_error !== 1'b0) begin n_fail++;
            $display("FAIL 7e2_flip_serr got=%b exp=0", stop_error); end
    endtask

    task automatic test_glitch();
        int d0, a0;
        d0 = done_cnt; a0 = active_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        n_tests++; if (done_cnt != d0) begin n_fail++;
            $display("FAIL glitch_pulses got=%0d exp=0", done_cnt - d0); end
        n_tests++; if (active_cnt != a0) begin n_fail++;
            $display("FAIL glitch_active got=%0d exp=0", active_cnt - a0); end
        n_tests++; if (data_parll !== 8'h55 || parity_error !== 1'b1) begin n_fail++;
            $display("FAIL glitch_hold got=%h/%b exp=55/1", data_parll, parity_error); end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 8, 2'b01, 1'b0, 1, 1'b1, 20);
        n_tests++; if (stop_error !== 1'b1) begin n_fail++;
            $display("FAIL frame_serr got=%b exp=1", stop_error); end
        n_tests++; if (data_parll !== 8'h3C) begin n_fail++;
            $display("FAIL frame_data got=%h exp=3c", data_parll); end
        n_tests++; if (parity_error !== 1'b0) begin n_fail++;
            $display("FAIL frame_perr got=%b exp=0", parity_error); end
        send_frame(8'h42, 8, 2'b00, 1'b0, 1, 1'b0, 20);
        n_tests++; if (stop_error !== 1'b0 || data_parll !== 8'h42) begin n_fail++;
            $display("FAIL frame_recover got=%b/%h exp=0/42", stop_error, data_parll); end
    endtask

    task automatic test_back_to_back();
        int d0, q0;
        d0 = done_cnt; q0 = got_q.size();
        send_frame(8'h01, 8, 2'b00, 1'b0, 1, 1'b0, 0);
        send_frame(8'hFE, 8, 2'b00, 1'b0, 1, 1'b0, 20);
        n_tests++; if (done_cnt - d0 !== 2) begin n_fail++;
            $display("FAIL b2b_pulses got=%0d exp=2", done_cnt - d0); end
        if (got_q.size() >= q0 + 2) begin
            n_tests++; if (got_q[q0] !== 8'h01) begin n_fail++;
                $display("FAIL b2b_first got=%h exp=01", got_q[q0]); end
            n_tests++; if (got_q[q0+1] !== 8'hFE) begin n_fail++;
                $display("FAIL b2b_second got=%h exp=fe", got_q[q0+1]); end
        end else begin
            n_tests++; n_fail++;
            $display("FAIL b2b_values got=%0d frames exp=2", got_q.size() - q0);
        end
    endtask

    task automatic test_reset_abort();
        int d0;
        logic [7:0] d;
        d = 8'h81;
        d0 = done_cnt;
        par_type = 2'b00; stop_bits = 1'b0; data_len = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        n_tests++; if (done_cnt != d0) begin n_fail++;
            $display("FAIL abort_pulses got=%0d exp=0", done_cnt - d0); end
        n_tests++; if (data_parll !== 8'h00 || active_flag !== 1'b0) begin n_fail++;
            $display("FAIL abort_state got=%h/%b exp=00/0", data_parll, active_flag); end
        send_frame(8'h81, 8, 2'b00, 1'b0, 1, 1'b0, 20);
        n_tests++; if (done_cnt - d0 !== 1 || data_parll !== 8'h81) begin n_fail++;
            $display("FAIL abort_next got=%0d/%h exp=1/81", done_cnt - d0, data_parll); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
